// File: rtl/msx_wait_gen.sv
// Z80/MSX /WAIT generator: inserts a programmable burst of wait cycles per bus
// cycle (M1, I/O, memory), drives an external inverting tri-state buffer.
module msx_wait_gen #(
  parameter int unsigned M1_WAITS  = 1,
  parameter int unsigned IO_WAITS  = 2,
  parameter int unsigned MEM_WAITS = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic nm1,
  input  logic nmreq,
  input  logic niorq,
  input  logic en,
  output logic wait_a,
  output logic wait_noe,
  output logic busy
);

  // state | meaning
  // IDLE  | no bus cycle being serviced, start conditions evaluated
  // WAIT  | wait_a asserted, counter running down
  // HOLD  | burst done (or none needed); waiting for all strobes to release
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wait_q, wait_d;
  logic       all_hi;
  logic       start;
  logic [2:0] n_sel;

  assign all_hi = nm1 & nmreq & niorq;

  // Start decode in priority order; INTA starts a zero-length "burst" so it
  // still parks in HOLD until the strobes release.
  always_comb begin
    start = 1'b1;
    n_sel = 3'd0;
    if (!nm1 && !nmreq)       n_sel = 3'(M1_WAITS);
    else if (!niorq && nm1)   n_sel = 3'(IO_WAITS);
    else if (!nmreq && nm1)   n_sel = 3'(MEM_WAITS);
    else if (!niorq && !nm1)  n_sel = 3'd0;
    else                      start = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (en && start) begin
          if (n_sel != 3'd0) begin
            state_d = WAIT;
            cnt_d   = n_sel - 3'd1;
            wait_d  = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      WAIT: begin
        if (all_hi) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          wait_d  = 1'b0;
        end else if (cnt_q == 3'd0) begin
          state_d = HOLD;
          wait_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HOLD: begin
        if (all_hi) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        wait_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign wait_a   = wait_q;
  assign wait_noe = ~wait_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/msx_wait_gen.md
MSX_WAIT_GEN -- requirements
Module: msx_wait_gen

Interface
REQ-001 Parameter M1_WAITS, default 1, wait cycles inserted on opcode-fetch (M1) cycles, range 0-7.
REQ-002 Parameter IO_WAITS, default 2, wait cycles inserted on I/O cycles, range 0-7.
REQ-003 Parameter MEM_WAITS, default 0, wait cycles inserted on non-M1 memory cycles, range 0-7.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  CPU clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 nm1  input  1  Z80 /M1, active-low.
REQ-008 nmreq  input  1  Z80 /MREQ, active-low.
REQ-009 niorq  input  1  Z80 /IORQ, active-low.
REQ-010 en  input  1  high = wait generation enabled.
REQ-011 wait_a  output  1  active-high wait request; drives the data input of the downstream inverting tri-state buffer, producing /WAIT.
REQ-012 wait_noe  output  1  active-low buffer enable; low only while wait_a is high; high otherwise, so the shared /WAIT line floats.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, HOLD.
REQ-015 All inputs are synchronous to clk and SHALL be sampled on its rising edge without extra synchronisers.
REQ-016 In IDLE, the start conditions SHALL be evaluated in priority order: M1 (nm1=0 and nmreq=0), then IO (niorq=0 and nm1=1), then MEM (nmreq=0 and nm1=1).
REQ-017 niorq=0 with nm1=0 (interrupt acknowledge) SHALL NOT start a wait; the FSM enters HOLD.
REQ-018 In IDLE with en=0, no start condition SHALL be acted on, and the FSM remains in IDLE.
REQ-019 On a start edge with selected count N>0, the FSM SHALL go to WAIT with wait_a=1 and wait_noe=0 registered on that same edge.
REQ-020 wait_a SHALL stay high for exactly N clock periods, then deassert with wait_noe=1 on the Nth following edge, when the FSM goes to HOLD.
REQ-021 On a start edge with N=0, the FSM SHALL go directly to HOLD without asserting wait_a.
REQ-022 The internal down-counter SHALL be 3 bits wide, loaded with N-1 on entry to WAIT, and leave WAIT on the edge where it is 0; it SHALL never wrap.
REQ-023 HOLD SHALL persist until nm1, nmreq and niorq are all sampled high, then return to IDLE, so one bus cycle yields at most one wait burst.
REQ-024 If all three strobes are sampled high while in WAIT (cycle aborted), the FSM SHALL go to IDLE on that edge and deassert wait_a.
REQ-025 en going low during WAIT SHALL NOT shorten the burst in progress.
REQ-026 A new bus cycle whose strobes fall on the same edge the FSM returns to IDLE SHALL be detected on the following edge.
REQ-027 wait_noe SHALL equal the inverse of wait_a at all times, both being registered outputs with no combinational path from inputs.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE, the counter 0, wait_a=0, wait_noe=1 and busy=0, independent of clk.
REQ-029 Reset asserted mid-WAIT SHALL immediately deassert wait_a and float the buffer.
REQ-030 After rst is released, the first start evaluation SHALL occur on the next rising edge.

Verification
REQ-031 Defaults, M1 fetch: nm1=nmreq=0 sampled at edge k -> wait_a=1, wait_noe=0 after edges k..k, cleared after edge k+1; busy until strobes high.
REQ-032 IO cycle, IO_WAITS=2: niorq=0, nm1=1 -> wait_a high exactly 2 periods; INTA (nm1=niorq=0) -> wait_a stays 0, busy=1 until strobes release.
REQ-033 MEM cycle with MEM_WAITS=0 -> wait_a never asserted, wait_noe stays 1, FSM passes HOLD->IDLE; en=0 on an IO cycle -> no wait.
REQ-034 IO_WAITS=7, strobes released after 3 wait cycles -> wait_a drops on that edge; strobes held low past burst -> exactly one burst.
REQ-035 rst pulsed between edges during WAIT -> wait_a=0, wait_noe=1 immediately; the next cycle after release is handled normally.
